// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

endpackage

// File: rtl/loader_byte_packer.sv
// Packs a byte stream into 32-bit words, first byte in the most significant lane.
module loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] ins;

    always_comb begin
        ins = word_q;
        case (cnt_q)
            2'd0: ins[31:24] = byte_i;
            2'd1: ins[23:16] = byte_i;
            2'd2: ins[15:8]  = byte_i;
            2'd3: ins[7:0]   = byte_i;
        endcase

        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (load_i) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = ins;
        end
    end

    // word_o includes the byte being accepted this cycle, so the caller can
    // capture a complete word on the same edge that the fourth byte lands.
    assign word_o      = ins;
    assign word_full_o = load_i && (cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader: byte stream in, word writes out, CPU held during load.
// Optional running checksum of written words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] checksum
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              start_acc;
    logic              byte_acc;
    logic              pack_clear;
    logic              pack_full;
    logic [WORD_W-1:0] pack_word;

    assign byte_acc = (state_q == COLLECT) && byte_valid;
    // Index is one bit wider than the address so a full-depth load can reach
    // its terminal count without the address wrapping first.
    assign idx_inc  = idx_q + {{ADDR_W{1'b0}}, 1'b1};

    loader_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (pack_clear),
        .load_i      (byte_acc),
        .byte_i      (byte_data),
        .word_o      (pack_word),
        .word_full_o (pack_full)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        start_acc  = 1'b0;
        pack_clear = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (word_count == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d      = word_count;
                        idx_d      = '0;
                        pack_clear = 1'b1;
                        state_d    = COLLECT;
                    end
                end
            end
            COLLECT: begin
                // Write address/data are registered here so they are stable
                // for the whole WRITE cycle and hold afterwards.
                if (pack_full) begin
                    addr_d  = idx_q[ADDR_W-1:0];
                    wdata_d = pack_word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == cnt_q) ? DONE : COLLECT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign byte_ready = (state_q == COLLECT);
    assign mem_we     = (state_q == WRITE);
    assign busy       = (state_q == COLLECT) || (state_q == WRITE);
    assign cpu_hold   = busy;
    assign done       = (state_q == DONE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (state_q == WRITE) begin
            csum_q <= csum_q + wdata_q;
        end
    end

    assign checksum = csum_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign checksum         = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic [31:0]       checksum;

    int checks = 0;
    int errors = 0;
    int bad_ready = 0;
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]       log_data[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            if (byte_ready) bad_ready++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W:0] n);
        word_count = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        for (int k = 0; k < 4; k++)
            send_byte(w[31-8*k -: 8], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
    endtask

    initial begin
        logic [31:0] exp_sum;
        int          n0;
        logic [7:0]  b;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_cpu_hold",   32'(cpu_hold),   32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        check("rst_checksum",   checksum,        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-length load from IDLE
        n0 = log_addr.size();
        word_count = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done",     32'(done),     32'd1);
        check("zero_cpu_hold", 32'(cpu_hold), 32'd0);
        check("zero_busy",     32'(busy),     32'd0);
        repeat (3) @(negedge clk);
        check("zero_no_write", 32'(log_addr.size()), 32'(n0));
        check("zero_hold_low", 32'(cpu_hold), 32'd0);

        // two-word load from DONE
        pulse_start(9'd2);
        check("l2_busy",       32'(busy),       32'd1);
        check("l2_cpu_hold",   32'(cpu_hold),   32'd1);
        check("l2_byte_ready", 32'(byte_ready), 32'd1);
        check("l2_done_clr",   32'(done),       32'd0);
        send_word(32'h20080005, 0);
        check("l2_w0_we",      32'(mem_we),     32'd1);
        check("l2_w0_addr",    32'(mem_addr),   32'd0);
        check("l2_w0_data",    mem_wdata,       32'h20080005);
        check("l2_w0_ready",   32'(byte_ready), 32'd0);
        send_word(32'h8C010004, 0);
        check("l2_w1_we",      32'(mem_we),     32'd1);
        check("l2_w1_addr",    32'(mem_addr),   32'd1);
        check("l2_w1_data",    mem_wdata,       32'h8C010004);
        check("l2_w1_hold",    32'(cpu_hold),   32'd1);
        @(negedge clk);
        check("l2_hold_fall",  32'(cpu_hold),   32'd0);
        check("l2_done",       32'(done),       32'd1);
        check("l2_busy_fall",  32'(busy),       32'd0);
        check("l2_we_low",     32'(mem_we),     32'd0);
        check("l2_addr_hold",  32'(mem_addr),   32'd1);
        check("l2_data_hold",  mem_wdata,       32'h8C010004);
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_sum = 32'hAC090009;
`else
        exp_sum = 32'h0;
`endif
        check("l2_checksum",   checksum,        exp_sum);

        // three-word load with random byte gaps
        log_addr.delete();
        log_data.delete();
        bad_ready = 0;
        pulse_start(9'd3);
        send_word(32'h12345678, 3);
        send_word(32'h9ABCDEF0, 3);
        send_word(32'h0F1E2D3C, 3);
        @(negedge clk);
        check("gap_count",  32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            check("gap_a0", 32'(log_addr[0]), 32'd0);
            check("gap_d0", log_data[0],      32'h12345678);
            check("gap_a1", 32'(log_addr[1]), 32'd1);
            check("gap_d1", log_data[1],      32'h9ABCDEF0);
            check("gap_a2", 32'(log_addr[2]), 32'd2);
            check("gap_d2", log_data[2],      32'h0F1E2D3C);
        end
        check("gap_ready_in_write", 32'(bad_ready), 32'd0);
        check("gap_done", 32'(done), 32'd1);

        // reset in the middle of the first word
        log_addr.delete();
        log_data.delete();
        pulse_start(9'd2);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",       32'(busy),       32'd0);
        check("arst_cpu_hold",   32'(cpu_hold),   32'd0);
        check("arst_byte_ready", 32'(byte_ready), 32'd0);
        check("arst_done",       32'(done),       32'd0);
        check("arst_mem_we",     32'(mem_we),     32'd0);
        check("arst_mem_addr",   32'(mem_addr),   32'd0);
        check("arst_mem_wdata",  mem_wdata,       32'd0);
        check("arst_checksum",   checksum,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(9'd1);
        send_word(32'h11223344, 0);
        @(negedge clk);
        check("arst_count", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() == 1) begin
            check("arst_a0", 32'(log_addr[0]), 32'd0);
            check("arst_d0", log_data[0],      32'h11223344);
        end
        check("arst_done_after", 32'(done), 32'd1);

        // start during COLLECT is ignored
        log_addr.delete();
        log_data.delete();
        pulse_start(9'd2);
        send_byte(8'h01, 0);
        word_count = 9'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_done", 32'(done), 32'd0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_word(32'h55667788, 0);
        @(negedge clk);
        check("ign_count", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check("ign_a0", 32'(log_addr[0]), 32'd0);
            check("ign_d0", log_data[0],      32'h01020304);
            check("ign_a1", 32'(log_addr[1]), 32'd1);
            check("ign_d1", log_data[1],      32'h55667788);
        end
        check("ign_done_after", 32'(done), 32'd1);
        check("ign_busy_after", 32'(busy), 32'd0);

        // checksum wrap-around
        pulse_start(9'd2);
        send_word(32'hFFFFFFFF, 0);
        send_word(32'h00000002, 0);
        @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_sum = 32'h00000001;
`else
        exp_sum = 32'h0;
`endif
        check("csum_wrap", checksum, exp_sum);
        check("csum_done", 32'(done), 32'd1);

        // full-depth load: last address 2**ADDR_W-1, no wrap before DONE
        log_addr.delete();
        log_data.delete();
        pulse_start(9'd256);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_word({b, 8'hA5, ~b, 8'h3C}, 0);
        end
        @(negedge clk);
        check("full_count", 32'(log_addr.size()), 32'd256);
        if (log_addr.size() == 256) begin
            check("full_first_addr", 32'(log_addr[0]),   32'd0);
            check("full_first_data", log_data[0],        32'h00A5FF3C);
            check("full_last_addr",  32'(log_addr[255]), 32'd255);
            check("full_last_data",  log_data[255],      32'hFFA5003C);
        end
        check("full_done", 32'(done),     32'd1);
        check("full_hold", 32'(cpu_hold), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
